// File: rtl/vluint_pkg.sv
// ----------------------------------------------------------------------------
// vluint_pkg
//
// Shared definitions for the 7-bit-group variable-length unsigned integer
// (LEB128-style) encoder and its decoder counterpart.
//
// Contents:
//   vlu_state_t      - FSM state encoding (IDLE / EMIT / DONE)
//   VLU_CONT_BIT     - bit position of the continuation flag in a byte
//   VLU_PAYLOAD_W    - payload bits carried per byte
//   MAX_BYTES()      - worst-case byte count for a value of a given width
//   vlu_count_width()- width of a byte counter able to hold MAX_BYTES (>= 3)
//
// Default widths for the decoder memory and the encoded value come from
// project-wide macros; fallbacks are provided so the package stands alone.
// ----------------------------------------------------------------------------
`ifndef DECODER_MEM_ADDR_WIDTH
`define DECODER_MEM_ADDR_WIDTH 16
`endif

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package vluint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } vlu_state_t;

    localparam int VLU_CONT_BIT  = 7;
    localparam int VLU_PAYLOAD_W = 7;

    // Largest number of bytes any VAL_W-bit value can need.
    function automatic int MAX_BYTES(input int val_w);
        return (val_w + VLU_PAYLOAD_W - 1) / VLU_PAYLOAD_W;
    endfunction

    // Counter width wide enough to hold MAX_BYTES itself, never below 3 bits
    // so the nbytes port keeps a stable minimum width for small values.
    function automatic int vlu_count_width(input int val_w);
        int w;
        w = $clog2(MAX_BYTES(val_w) + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/vluint7_enc.sv
// ----------------------------------------------------------------------------
// vluint7_enc
//
// Encodes an unsigned value into a sequence of bytes, 7 payload bits per byte,
// least-significant group first. Bit 7 of each byte is a continuation flag
// that is set on every byte except the last. Bytes are written one at a time
// to an external byte memory through a simple write/ready handshake.
//
// Parameters:
//   ADDR_W   - byte-memory address width
//   VAL_W    - width of the value to encode
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   beg        in   start request, only honoured while idle
//   addr       in   address of the first output byte (latched on start)
//   value      in   value to encode (latched on start)
//   mem_ready  in   memory accepts the current write this cycle
//   mem_we     out  byte write request
//   mem_addr   out  byte write address
//   mem_data   out  byte write data {continuation, payload[6:0]}
//   busy       out  high whenever the encoder is not idle
//   done       out  one-cycle completion pulse
//   addr_out   out  address just past the last written byte (valid from done)
//   nbytes     out  number of bytes written (valid from done)
// ----------------------------------------------------------------------------
module vluint7_enc
    import vluint_pkg::*;
#(
    parameter int ADDR_W = `DECODER_MEM_ADDR_WIDTH,
    parameter int VAL_W  = `INSTR_WIDTH,
    localparam int CNT_W = vlu_count_width(VAL_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VAL_W-1:0]  value,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_out,
    output logic [CNT_W-1:0]  nbytes
);

    // Byte presented for the current remaining value: continuation set when
    // anything is left above the lowest payload group.
    function automatic logic [7:0] enc_byte(input logic [VAL_W-1:0] s);
        return {(s >> VLU_PAYLOAD_W) != '0, s[VLU_PAYLOAD_W-1:0]};
    endfunction

    vlu_state_t        state_q,    state_d;
    logic [VAL_W-1:0]  sr_q,       sr_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [CNT_W-1:0]  nbytes_q,   nbytes_d;
    logic              mem_we_q,   mem_we_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic              xfer;

    // A byte leaves the block only when the write request meets ready.
    assign xfer = (state_q == ST_EMIT) && mem_we_q && mem_ready;

    // Next-state and next-output computation. All outputs are derived from the
    // next state so that they are registered and line up with the state they
    // describe.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        addr_cnt_d = addr_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_out_d = addr_out_q;
        nbytes_d   = nbytes_q;

        case (state_q)
            ST_IDLE: begin
                if (beg) begin
                    sr_d       = value;
                    addr_cnt_d = addr;
                    byte_cnt_d = '0;
                    state_d    = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (xfer) begin
                    sr_d       = sr_q >> VLU_PAYLOAD_W;
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    // The byte just accepted was the last one when its
                    // continuation flag was clear; publish the results now so
                    // they are already valid while done is high.
                    if (!mem_data_q[VLU_CONT_BIT]) begin
                        state_d    = ST_DONE;
                        addr_out_d = addr_cnt_d;
                        nbytes_d   = byte_cnt_d;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_we_d   = (state_d == ST_EMIT);
        mem_data_d = (state_d == ST_EMIT) ? enc_byte(sr_d) : 8'h00;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low clear. Clearing
    // mid-encode simply abandons the transfer; bytes already in memory stay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            addr_cnt_q <= '0;
            byte_cnt_q <= '0;
            addr_out_q <= '0;
            nbytes_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_data_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            addr_cnt_q <= addr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_out_q <= addr_out_d;
            nbytes_q   <= nbytes_d;
            mem_we_q   <= mem_we_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = addr_cnt_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign addr_out = addr_out_q;
    assign nbytes   = nbytes_q;

endmodule

// File: doc/vluint7_enc.md
VLUINT7_ENC -- requirements
Module: vluint7_enc

Interface
REQ-001 SHALL have parameter ADDR_W, default `DECODER_MEM_ADDR_WIDTH, the byte-memory address width.
REQ-002 SHALL have parameter VAL_W, default `INSTR_WIDTH, the width of the value to encode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port beg, input, 1 bit: start request; sampled in IDLE only.
REQ-006 SHALL have port addr, input, ADDR_W bits: address of the first output byte; latched on an accepted beg.
REQ-007 SHALL have port value, input, VAL_W bits: unsigned value to encode; latched on an accepted beg.
REQ-008 SHALL have port mem_ready, input, 1 bit: the memory accepts the current write this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit: byte write request.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: write address.
REQ-011 SHALL have port mem_data, output, 8 bits: write data, bit 7 = continuation, bits 6:0 = payload.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port addr_out, output, ADDR_W bits: first address after the last written byte; valid from done onward.
REQ-015 SHALL have port nbytes, output, 3 bits minimum: number of bytes written; valid from done onward.

Function
REQ-016 SHALL use an FSM with states IDLE, EMIT and DONE.
REQ-017 IDLE with beg=1 SHALL latch value into shift register sr, latch addr into the address counter, clear the byte counter, and go to EMIT.
REQ-018 EMIT SHALL drive mem_we=1, mem_addr = the counter, and mem_data = {(sr>>7)!=0, sr[6:0]}, so that payload is emitted least-significant group first.
REQ-019 In EMIT, when mem_we and mem_ready are both high, the block SHALL set sr<=sr>>7, increment the address counter and increment the byte counter.
REQ-020 After the transfer in REQ-019, if the written byte had bit 7 = 0 the FSM SHALL go to DONE; otherwise it SHALL stay in EMIT.
REQ-021 In EMIT with mem_ready=0, mem_addr and mem_data SHALL stay stable and mem_we SHALL stay high; there is no timeout.
REQ-022 DONE SHALL assert done for exactly one cycle, update addr_out and nbytes, and return to IDLE.
REQ-023 addr_out and nbytes SHALL hold their values until the next DONE.
REQ-024 Latency with mem_ready held high: beg accepted in cycle 0 -> bytes written in cycles 1..N -> done in cycle N+1.
REQ-025 The next beg SHALL be accepted in cycle N+2.
REQ-026 value=0 SHALL produce exactly one byte, 0x00.
REQ-027 Byte count SHALL be max(1, ceil(bitlen(value)/7)), never exceeding MAX_BYTES = ceil(VAL_W/7).
REQ-028 The address counter SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-029 beg while busy SHALL be ignored; no queuing.
REQ-030 beg coincident with done SHALL be ignored; the state is DONE, not IDLE.
REQ-031 mem_we SHALL be 0 in IDLE and in DONE.

Reset
REQ-032 With reset=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-033 Under reset, mem_we, busy and done SHALL be 0.
REQ-034 Under reset, mem_addr, mem_data, addr_out, nbytes, sr and both counters SHALL be 0.
REQ-035 Reset during EMIT SHALL abort the encode: no further writes and no done pulse; bytes already written stay in memory.
REQ-036 The first beg SHALL be accepted on the first edge with reset=1.

Structure
REQ-037 Shared package vluint_pkg SHALL hold the state enum, VLU_CONT_BIT=7, VLU_PAYLOAD_W=7 and a MAX_BYTES function of VAL_W, for reuse by vluint7.
REQ-038 The block SHALL be a single module with no sub-module.
REQ-039 The memory is external; the block SHALL NOT instantiate single_port_sync_ram.

Verification (ADDR_W=16, VAL_W=32, mem_ready=1 unless stated)
REQ-040 value=0, addr=0x0010 -> one write 0x00@0x0010; done in cycle 2; addr_out=0x0011; nbytes=1.
REQ-041 value=300, addr=0x0100 -> 0xAC@0x0100, 0x02@0x0101; addr_out=0x0102; nbytes=2.
REQ-042 value=0xFFFFFFFF, addr=0 -> 0xFF,0xFF,0xFF,0xFF,0x0F at addresses 0..4; nbytes=5.
REQ-043 value=128, addr=0xFFFF, mem_ready low for 3 cycles during byte 1 -> 0x80@0xFFFF held stable 4 cycles, then 0x01@0x0000; addr_out=0x0001.
REQ-044 beg pulsed during EMIT and again with done -> both ignored; only one encode occurs.
REQ-045 reset=0 after byte 1 of value=0x4000 -> only 0x80 written, no done, all outputs 0; a new beg then works normally.
